// File: rtl/bcd_serial_add_ctrl_if.sv
// Bundle of the request/result signals of the serial BCD adder controller.
//   master : drives Start, A, B, Cin; observes Sum, Cout, Busy, Done, Err
//   slave  : the controller side (inputs/outputs mirrored)
// DIGITS must match the DIGITS parameter of the connected controller.
interface bcd_serial_add_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  Start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Cin;
  logic [4*DIGITS-1:0]   Sum;
  logic                  Cout;
  logic                  Busy;
  logic                  Done;
  logic                  Err;

  modport master (
    output Start, A, B, Cin,
    input  Sum, Cout, Busy, Done, Err
  );

  modport slave (
    input  Start, A, B, Cin,
    output Sum, Cout, Busy, Done, Err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencing controller for a multi-digit BCD adder. On Start (in idle) it captures two packed
// BCD operands and carry-in, then runs one shared single-digit add/correct step per clock,
// least-significant digit first, building the packed sum. Operands holding any digit > 9 are
// rejected with Err and no add cycles.
// Ports:
//   Clock : system clock, rising edge
//   Reset : asynchronous, active-high; clears all state
//   bus   : slave side of bcd_serial_add_ctrl_if
//           Start/A/B/Cin in; Sum/Cout/Err (registered), Busy/Done (decoded from state) out
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int unsigned W       = 4 * DIGITS;
  localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StFin} state_e;

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_err;
  logic [IdxW-1:0] r_idx;

  logic            w_bad;
  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [4:0]      w_t;
  logic            w_gt9;
  logic [3:0]      w_digit;
  logic [W-1:0]    w_sum_nxt;

  // Operand validity is judged on the live inputs, at the capturing edge.
  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bus.A[4*d +: 4] > 4'd9 || bus.B[4*d +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // Select the current digit pair from the captured operands.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_idx == IdxW'(d)) begin
        w_a_dig = r_a[4*d +: 4];
        w_b_dig = r_b[4*d +: 4];
      end
    end
  end

  // One-digit BCD add with decimal correction: t in 0..19, t-10 == (t+6) mod 16.
  always_comb begin
    w_t     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};
    w_gt9   = (w_t > 5'd9);
    w_digit = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
  end

  // Merge the corrected digit into its slot; higher digits stay 0 from the capture clear.
  always_comb begin
    w_sum_nxt = r_sum;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_idx == IdxW'(d)) w_sum_nxt[4*d +: 4] = w_digit;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.Start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.Cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= w_bad;
            r_state <= w_bad ? StFin : StAdd;
          end
        end
        StAdd: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_gt9;
          if (r_idx == LastIdx) begin
            r_cout  <= w_gt9;
            r_state <= StFin;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StFin: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.Sum  = r_sum;
  assign bus.Cout = r_cout;
  assign bus.Err  = r_err;
  assign bus.Busy = (r_state == StAdd);
  assign bus.Done = (r_state == StFin);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS = 4): directed vector table, hand-written
// multi-cycle sequences (ripple trace, Start ignored while busy, Start held, async reset) and
// randomized operations checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         er;
    bit           trace;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as decimal numbers and add them.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                output logic [W-1:0] s, output logic co, output logic er);
    int va, vb, tot, lim;
    va  = 0;
    vb  = 0;
    er  = 1'b0;
    lim = 1;
    for (int d = int'(D) - 1; d >= 0; d--) begin
      if (a[4*d +: 4] > 4'd9 || b[4*d +: 4] > 4'd9) er = 1'b1;
      va  = va * 10 + int'(a[4*d +: 4]);
      vb  = vb * 10 + int'(b[4*d +: 4]);
      lim = lim * 10;
    end
    s  = '0;
    co = 1'b0;
    if (!er) begin
      tot = va + vb + int'(cin);
      co  = (tot >= lim);
      tot = tot % lim;
      for (int d = 0; d < int'(D); d++) begin
        s[4*d +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end
  endfunction

  // One Start pulse; checks latency, busy cycles, result, optional per-digit trace.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec,
                        input logic ee, input bit trace);
    int lat;
    int busy_n;
    logic [W-1:0] mask;
    lat    = -1;
    busy_n = 0;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    for (int n = 0; n <= int'(D) + 3; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.Done) begin
        lat = n;
        break;
      end
      if (bus.Busy) busy_n++;
      if (trace) begin
        mask = '0;
        for (int d = 0; d < n; d++) mask[4*d +: 4] = 4'hF;
        check({tag, " trace sum"}, 32'(bus.Sum), 32'(es & mask));
        check({tag, " trace cout"}, 32'(bus.Cout), 32'd0);
      end
    end
    check({tag, " latency"}, lat, ee ? 0 : int'(D));
    check({tag, " busy cycles"}, busy_n, ee ? 0 : int'(D));
    check({tag, " sum"}, 32'(bus.Sum), 32'(es));
    check({tag, " cout"}, 32'(bus.Cout), 32'(ec));
    check({tag, " err"}, 32'(bus.Err), 32'(ee));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(bus.Done), 32'd0);
    check({tag, " hold sum"}, 32'(bus.Sum), 32'(es));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] ra, rb, es;
    logic rc, ec, ee;
    int lat;
    int dn;
    int done_cyc[3];

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'h0003, 16'h0F00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{16'h0815, 16'h0185, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    #1;
    check("reset sum", 32'(bus.Sum), 32'd0);
    check("reset cout", 32'(bus.Cout), 32'd0);
    check("reset busy", 32'(bus.Busy), 32'd0);
    check("reset done", 32'(bus.Done), 32'd0);
    check("reset err", 32'(bus.Err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co,
             vecs[i].er, vecs[i].trace);
    end

    // Start re-pulsed with other operands during ADD must be ignored.
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h5678; bus.Cin = 1'b0; bus.Start = 1'b1;
    @(posedge clk); #1; bus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b1; bus.Start = 1'b1;
    lat = -1;
    for (int n = 2; n <= int'(D) + 4; n++) begin
      @(posedge clk); #1;
      bus.Start = 1'b0;
      if (bus.Done) begin
        lat = n;
        break;
      end
    end
    check("repulse latency", lat, int'(D));
    check("repulse sum", 32'(bus.Sum), 32'h6912);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check("repulse no queued op", 32'(bus.Busy), 32'd0);
    end

    // Start held high: captures every DIGITS+2 cycles.
    @(negedge clk);
    bus.A = 16'h0250; bus.B = 16'h0749; bus.Cin = 1'b1; bus.Start = 1'b1;
    dn = 0;
    for (int n = 0; n < 40 && dn < 3; n++) begin
      @(posedge clk); #1;
      if (bus.Done) begin
        done_cyc[dn] = cyc;
        dn++;
        check("held sum", 32'(bus.Sum), 32'h1000);
      end
    end
    check("held done count", dn, 3);
    if (dn == 3) begin
      check("held spacing 1", done_cyc[1] - done_cyc[0], int'(D) + 2);
      check("held spacing 2", done_cyc[2] - done_cyc[1], int'(D) + 2);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (int'(D) + 3) @(posedge clk);

    // Asynchronous reset mid-ADD, after digit 1 is written.
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h5678; bus.Cin = 1'b0; bus.Start = 1'b1;
    @(posedge clk); #1; bus.Start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre-reset partial sum", 32'(bus.Sum), 32'h0012);
    check("pre-reset busy", 32'(bus.Busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset sum", 32'(bus.Sum), 32'd0);
    check("async reset busy", 32'(bus.Busy), 32'd0);
    check("async reset done", 32'(bus.Done), 32'd0);
    check("async reset cout", 32'(bus.Cout), 32'd0);
    check("async reset err", 32'(bus.Err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle", 32'(bus.Busy), 32'd0);
    run_op("after reset", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1);

    // Randomized operations against the decimal model.
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < int'(D); d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      end
      model(ra, rb, rc, es, ec, ee);
      run_op($sformatf("rand%0d", i), ra, rb, rc, es, ec, ee, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
